// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding a baud-divided serialiser.
// Frames are sent back-to-back whenever the FIFO holds data at the end of a stop bit.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_HZ / BAUD must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   baud_q, baud_n;
    logic [2:0]      bit_q, bit_n;
    logic [7:0]      shift_q, shift_n;
    logic            tx_n;
    logic            pop;
    logic            wr_en;
    logic            baud_done;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [7:0]      mem [DEPTH];

    // Refusal when full depends on count alone, even if a pop happens on the same edge.
    assign wr_ready  = (count != CNTW'(DEPTH));
    assign wr_en     = wr_valid && wr_ready;
    assign busy      = (state_q != IDLE);
    assign baud_done = (baud_q == CW'(DIV - 1));

    // Next-state, pop decision and next line level.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q + CW'(1);
        bit_n   = bit_q;
        shift_n = shift_q;
        pop     = 1'b0;
        tx_n    = 1'b1;

        case (state_q)
            IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = shift_q >> 1;
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx      <= 1'b1;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            tx      <= tx_n;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=16, DEPTH=4 with a line decoder watching tx.
module tb_uart_tx_fifo;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] count;

    uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx       (tx),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int busy_cycles = 0;
    int max_count = 0;
    int rdy_err = 0;
    int starts[$];
    int decoded[$];
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line monitor: samples mid-bit on falling edges and logs frame start cycles.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cycles++;
            if (!reset) begin
                if (int'(count) > max_count) max_count = int'(count);
                if (wr_ready !== (count != 3'd4)) rdy_err++;
            end
            if (reset) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (tx === 1'b0) begin
                    dec_active = 1'b1;
                    dec_cnt    = 0;
                    starts.push_back(cyc);
                end
            end else begin
                dec_cnt++;
                if (dec_cnt >= 24 && dec_cnt <= 136 && (dec_cnt % 16) == 8)
                    dec_byte[3'((dec_cnt - 24) / 16)] = tx;
                if (dec_cnt == 152) begin
                    dec_active = 1'b0;
                    decoded.push_back(tx === 1'b1 ? int'(dec_byte) : (int'(dec_byte) | 'h100));
                end
            end
        end
    end

    task automatic clear_logs();
        starts.delete();
        decoded.delete();
        busy_cycles = 0;
        max_count = 0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int guard = 0;
        while (decoded.size() < n && guard < 3000) begin
            tick();
            guard++;
        end
        check(tag, decoded.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int guard = 0;
        while ((busy !== 1'b0 || count !== 3'd0) && guard < 3000) begin
            tick();
            guard++;
        end
        check(tag, {busy, count}, 4'h0);
    endtask

    // Holds wr_valid continuously; returns frame starts seen when byte index 5 is accepted.
    task automatic send_stream(input string tag, input int n, input logic [7:0] base,
                               output int starts_at_6);
        int i = 0;
        int guard = 0;
        logic rdy;
        starts_at_6 = -1;
        while (i < n && guard < 5000) begin
            wr_data  = base + 8'(i);
            wr_valid = 1'b1;
            rdy      = wr_ready;
            tick();
            if (rdy) begin
                if (i == 5) starts_at_6 = starts.size();
                i++;
            end
            guard++;
        end
        wr_valid = 1'b0;
        check(tag, i, n);
    endtask

    initial begin
        int s6;
        int s0;
        int guard;
        logic [7:0] pat;
        logic ok;
        logic lvl;

        tick();
        tick();
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", count, 0);
        check("reset_wr_ready", wr_ready, 1);
        reset = 1'b0;
        tick();

        // Single byte 0x55: level pattern, latency and busy width.
        clear_logs();
        wr_data = 8'h55;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("t1_count_after_write", count, 1);
        check("t1_tx_idle_after_write", tx, 1);
        check("t1_busy_after_write", busy, 0);
        tick();
        check("t1_tx_fall", tx, 0);
        check("t1_busy_rise", busy, 1);
        check("t1_count_after_pop", count, 0);
        pat = 8'h55;
        for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : pat[b-1];
            ok = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                if (tx !== lvl) ok = 1'b0;
                tick();
            end
            check($sformatf("t1_bit%0d_level", b), ok, 1);
        end
        check("t1_busy_end", busy, 0);
        check("t1_busy_cycles", busy_cycles, 160);
        check("t1_decoded_n", decoded.size(), 1);
        if (decoded.size() >= 1) check("t1_byte", decoded[0], 'h55);

        // Three consecutive writes: contiguous frames.
        tick();
        clear_logs();
        wr_valid = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h43; tick();
        wr_valid = 1'b0;
        wait_bytes("t2_timeout", 3);
        wait_idle("t2_idle");
        check("t2_busy_cycles", busy_cycles, 480);
        if (decoded.size() == 3) begin
            check("t2_byte0", decoded[0], 'h41);
            check("t2_byte1", decoded[1], 'h42);
            check("t2_byte2", decoded[2], 'h43);
        end
        if (starts.size() == 3) begin
            check("t2_gap01", starts[1] - starts[0], 160);
            check("t2_gap12", starts[2] - starts[1], 160);
        end

        // Full FIFO: 6 bytes with wr_valid held.
        tick();
        clear_logs();
        send_stream("t3_accept_all", 6, 8'hA0, s6);
        check("t3_6th_after_2nd_pop", s6, 2);
        check("t3_max_count", max_count, 4);
        wait_bytes("t3_timeout", 6);
        wait_idle("t3_idle");
        for (int i = 0; i < 6 && i < decoded.size(); i++)
            check($sformatf("t3_byte%0d", i), decoded[i], 'hA0 + i);

        // Pointer wrap: 12 distinct bytes.
        tick();
        clear_logs();
        send_stream("t4_accept_all", 12, 8'h00, s6);
        wait_bytes("t4_timeout", 12);
        wait_idle("t4_idle");
        check("t4_count_le4", max_count <= 4, 1);
        check("t4_count_end", count, 0);
        ok = 1'b1;
        for (int i = 0; i < 12 && i < decoded.size(); i++)
            if (decoded[i] != i) ok = 1'b0;
        check("t4_order", ok, 1);

        // Reset during data bit 3 with two bytes queued.
        tick();
        clear_logs();
        wr_valid = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_valid = 1'b0;
        guard = 0;
        while (starts.size() < 1 && guard < 100) begin tick(); guard++; end
        check("t5_frame_started", starts.size(), 1);
        s0 = (starts.size() > 0) ? starts[0] : cyc;
        guard = 0;
        while (cyc < s0 + 70 && guard < 200) begin tick(); guard++; end
        check("t5_queued_before_reset", count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_tx_after_reset", tx, 1);
        check("t5_busy_after_reset", busy, 0);
        check("t5_count_after_reset", count, 0);
        for (int i = 0; i < 400; i++) tick();
        check("t5_no_new_frames", starts.size(), 1);
        check("t5_no_decoded", decoded.size(), 0);
        clear_logs();
        wr_data = 8'hA5;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        wait_bytes("t5_timeout", 1);
        if (decoded.size() >= 1) check("t5_byte_a5", decoded[0], 'hA5);
        wait_idle("t5_idle");

        // Write landing on the final STOP clock: one idle clock before the next frame.
        tick();
        clear_logs();
        wr_data = 8'h3C;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 160; i++) tick();
        wr_data = 8'h0F;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("t6_idle_gap_busy", busy, 0);
        check("t6_idle_gap_count", count, 1);
        wait_bytes("t6_timeout", 2);
        wait_idle("t6_idle");
        if (starts.size() == 2) check("t6_start_gap", starts[1] - starts[0], 161);
        if (decoded.size() == 2) begin
            check("t6_byte0", decoded[0], 'h3C);
            check("t6_byte1", decoded[1], 'h0F);
        end

        check("wr_ready_tracks_count", rdy_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
